// File: rtl/text_editor_pkg.sv
// Shared constants and encodings for the UART text editor datapath.
//   - ASCII control/printable constants used by the byte interpreter
//   - FSM, escape-parser and cursor-operation encodings
//   - is_printable(): 0x20..0x7E test
package text_editor_pkg;

  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_ESC    = 8'h1B;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_B      = 8'h42;
  localparam logic [7:0] CH_C      = 8'h43;
  localparam logic [7:0] CH_D      = 8'h44;
  localparam logic [7:0] CH_TILDE  = 8'h7E;

  localparam logic [6:0] CHAR_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ECHO = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ESC_NONE = 2'd0,
    ESC_ESC  = 2'd1,
    ESC_CSI  = 2'd2
  } esc_e;

  typedef enum logic [2:0] {
    CUR_NOP       = 3'd0,
    CUR_INC_WRAP  = 3'd1,
    CUR_NEWLINE   = 3'd2,
    CUR_DEC       = 3'd3,
    CUR_UP_SAT    = 3'd4,
    CUR_DOWN_SAT  = 3'd5,
    CUR_RIGHT_SAT = 3'd6,
    CUR_LEFT_SAT  = 3'd7
  } cur_op_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_SPACE) && (b <= CH_TILDE);
  endfunction

endpackage

// File: rtl/cursor_counter.sv
// Cursor x/y position registers.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (position -> 0,0)
//   op        cursor operation applied at the next clock edge
//   x, y      current cursor column / row
// INC_WRAP advances one column, wrapping to the next row and from the
// last row back to row 0. DEC is the backspace move (no-op at column 0).
module cursor_counter
  import text_editor_pkg::*;
#(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  cur_op_e          op,
  output logic [COL_W-1:0] x,
  output logic [ROW_W-1:0] y
);

  localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] X_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] Y_ONE = ROW_W'(1);

  logic [COL_W-1:0] x_q, x_d;
  logic [ROW_W-1:0] y_q, y_d;
  logic [ROW_W-1:0] y_wrap;

  assign y_wrap = (y_q == Y_MAX) ? '0 : y_q + Y_ONE;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (op)
      CUR_INC_WRAP: begin
        if (x_q == X_MAX) begin
          x_d = '0;
          y_d = y_wrap;
        end else begin
          x_d = x_q + X_ONE;
        end
      end
      CUR_NEWLINE: begin
        x_d = '0;
        y_d = y_wrap;
      end
      CUR_DEC, CUR_LEFT_SAT: begin
        if (x_q != '0) x_d = x_q - X_ONE;
      end
      CUR_RIGHT_SAT: begin
        if (x_q != X_MAX) x_d = x_q + X_ONE;
      end
      CUR_UP_SAT: begin
        if (y_q != '0) y_d = y_q - Y_ONE;
      end
      CUR_DOWN_SAT: begin
        if (y_q != Y_MAX) y_d = y_q + Y_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/uart_text_cursor_ctrl.sv
// UART RX consumer for the text editor: pops bytes from the RX FIFO,
// interprets printable ASCII, BS, CR/LF and ESC '[' A/B/C/D arrows, keeps
// the cursor and issues one-cycle writes to the VGA text RAM.
// Build option: define UART_ECHO_EN to echo every raw byte to the TX FIFO.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rx_empty, rd_data  RX FIFO status / head byte (first-word-fall-through)
//   rd_uart            RX FIFO pop strobe
//   tx_full            TX FIFO full
//   wr_uart, wr_data   TX FIFO push strobe / echo byte
//   we, wr_x, wr_y     text RAM write strobe and address
//   wr_char            text RAM character code
//   cur_x, cur_y       cursor position
//
// state   | meaning
// IDLE    | waiting for a byte; latches it and pops the FIFO
// EXEC    | interprets the latched byte (pop strobe is high here)
// ECHO    | waits for TX space, then pushes the raw byte (UART_ECHO_EN only)
module uart_text_cursor_ctrl
  import text_editor_pkg::*;
#(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_empty,
  input  logic [7:0]       rd_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [7:0]       wr_data,
  output logic             we,
  output logic [COL_W-1:0] wr_x,
  output logic [ROW_W-1:0] wr_y,
  output logic [6:0]       wr_char,
  output logic [COL_W-1:0] cur_x,
  output logic [ROW_W-1:0] cur_y
);

  localparam logic [COL_W-1:0] X_ONE = COL_W'(1);

  state_e           state_q, state_d;
  esc_e             esc_q, esc_d;
  logic [7:0]       byte_q, byte_d;
  logic             rd_uart_q, rd_uart_d;
  logic             we_q, we_d;
  logic [COL_W-1:0] wr_x_q, wr_x_d;
  logic [ROW_W-1:0] wr_y_q, wr_y_d;
  logic [6:0]       wr_char_q, wr_char_d;
  cur_op_e          cur_op;

`ifdef UART_ECHO_EN
  logic             wr_uart_q, wr_uart_d;
  logic [7:0]       wr_data_q, wr_data_d;
`endif

  cursor_counter #(
    .COLS (COLS),
    .ROWS (ROWS),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_cursor (
    .clk(clk),
    .rst(rst),
    .op (cur_op),
    .x  (cur_x),
    .y  (cur_y)
  );

  always_comb begin
    state_d   = state_q;
    esc_d     = esc_q;
    byte_d    = byte_q;
    rd_uart_d = 1'b0;
    we_d      = 1'b0;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_char_d = wr_char_q;
    cur_op    = CUR_NOP;
`ifdef UART_ECHO_EN
    wr_uart_d = 1'b0;
    wr_data_d = wr_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          byte_d    = rd_data;
          rd_uart_d = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
`ifdef UART_ECHO_EN
        state_d = ST_ECHO;
`else
        state_d = ST_IDLE;
`endif
        case (esc_q)
          ESC_NONE: begin
            if (is_printable(byte_q)) begin
              we_d      = 1'b1;
              wr_x_d    = cur_x;
              wr_y_d    = cur_y;
              wr_char_d = byte_q[6:0];
              cur_op    = CUR_INC_WRAP;
            end else if (byte_q == CH_BS) begin
              // Backspace blanks the cell it moves onto.
              if (cur_x != '0) begin
                we_d      = 1'b1;
                wr_x_d    = cur_x - X_ONE;
                wr_y_d    = cur_y;
                wr_char_d = CHAR_SPACE;
                cur_op    = CUR_DEC;
              end
            end else if (byte_q == CH_CR || byte_q == CH_LF) begin
              cur_op = CUR_NEWLINE;
            end else if (byte_q == CH_ESC) begin
              esc_d = ESC_ESC;
            end
          end
          ESC_ESC: begin
            esc_d = (byte_q == CH_LBRACK) ? ESC_CSI : ESC_NONE;
          end
          ESC_CSI: begin
            esc_d = ESC_NONE;
            case (byte_q)
              CH_A:    cur_op = CUR_UP_SAT;
              CH_B:    cur_op = CUR_DOWN_SAT;
              CH_C:    cur_op = CUR_RIGHT_SAT;
              CH_D:    cur_op = CUR_LEFT_SAT;
              default: cur_op = CUR_NOP;
            endcase
          end
          default: esc_d = ESC_NONE;
        endcase
      end
`ifdef UART_ECHO_EN
      ST_ECHO: begin
        if (!tx_full) begin
          wr_uart_d = 1'b1;
          wr_data_d = byte_q;
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      esc_q     <= ESC_NONE;
      byte_q    <= '0;
      rd_uart_q <= 1'b0;
      we_q      <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_char_q <= '0;
`ifdef UART_ECHO_EN
      wr_uart_q <= 1'b0;
      wr_data_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      esc_q     <= esc_d;
      byte_q    <= byte_d;
      rd_uart_q <= rd_uart_d;
      we_q      <= we_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_char_q <= wr_char_d;
`ifdef UART_ECHO_EN
      wr_uart_q <= wr_uart_d;
      wr_data_q <= wr_data_d;
`endif
    end
  end

  assign rd_uart = rd_uart_q;
  assign we      = we_q;
  assign wr_x    = wr_x_q;
  assign wr_y    = wr_y_q;
  assign wr_char = wr_char_q;

`ifdef UART_ECHO_EN
  assign wr_uart = wr_uart_q;
  assign wr_data = wr_data_q;
`else
  // Without echo the TX side is inert; tx_full is intentionally ignored.
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign wr_uart = 1'b0;
  assign wr_data = 8'h00;
`endif

endmodule

// File: tb/tb_uart_text_cursor_ctrl.sv
module tb_uart_text_cursor_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_empty = 1'b1;
  logic [7:0]       rd_data = 8'h00;
  logic             tx_full = 1'b0;
  logic             rd_uart, wr_uart, we;
  logic [7:0]       wr_data;
  logic [COL_W-1:0] wr_x, cur_x;
  logic [ROW_W-1:0] wr_y, cur_y;
  logic [6:0]       wr_char;

  uart_text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rd_data(rd_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .wr_data(wr_data), .we(we), .wr_x(wr_x),
    .wr_y(wr_y), .wr_char(wr_char), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] x;
    logic [4:0] y;
    logic [6:0] c;
  } wr_t;

  logic [7:0] rx_q[$];
  wr_t        obs_w[$], exp_w[$];
  logic [7:0] obs_e[$], exp_e[$];
  int rd_cnt = 0, dbl_cnt = 0, sent = 0;
  logic rd_prev = 1'b0;
  int errors = 0, checks = 0;

  // RX FIFO model: first-word-fall-through, popped on the strobe.
  always @(posedge clk) if (!rst && rd_uart && rx_q.size() > 0) void'(rx_q.pop_front());
  always @(negedge clk) begin
    rx_empty = (rx_q.size() == 0);
    rd_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (we) obs_w.push_back({wr_x, wr_y, wr_char});
      if (rd_uart) rd_cnt++;
      if (rd_uart && rd_prev) dbl_cnt++;
      if (wr_uart) obs_e.push_back(wr_data);
      rd_prev = rd_uart;
    end else begin
      rd_prev = 1'b0;
    end
  end

  // Reference model: cursor, escape mode (0 none, 1 after ESC, 2 CSI).
  int mx = 0, my = 0, mesc = 0;

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    if (mesc == 0) begin
      if (b >= 8'h20 && b <= 8'h7E) begin
        w.x = 7'(mx); w.y = 5'(my); w.c = b[6:0];
        exp_w.push_back(w);
        mx = mx + 1;
        if (mx == COLS) begin mx = 0; my = (my + 1) % ROWS; end
      end else if (b == 8'h08) begin
        if (mx > 0) begin
          mx = mx - 1;
          w.x = 7'(mx); w.y = 5'(my); w.c = 7'h20;
          exp_w.push_back(w);
        end
      end else if (b == 8'h0D || b == 8'h0A) begin
        mx = 0; my = (my + 1) % ROWS;
      end else if (b == 8'h1B) begin
        mesc = 1;
      end
    end else if (mesc == 1) begin
      mesc = (b == 8'h5B) ? 2 : 0;
    end else begin
      if (b == 8'h41 && my > 0) my = my - 1;
      if (b == 8'h42 && my < ROWS - 1) my = my + 1;
      if (b == 8'h43 && mx < COLS - 1) mx = mx + 1;
      if (b == 8'h44 && mx > 0) mx = mx - 1;
      mesc = 0;
    end
`ifdef UART_ECHO_EN
    exp_e.push_back(b);
`endif
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    model_byte(b);
    sent++;
  endtask

  task automatic send3(input logic [7:0] k);
    send(8'h1B); send(8'h5B); send(k);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic clear_obs();
    obs_w.delete(); exp_w.delete(); obs_e.delete(); exp_e.delete();
    rd_cnt = 0; dbl_cnt = 0; sent = 0;
  endtask

  task automatic verify(input string tag);
    int n = 0;
    while (rx_q.size() != 0 && n < 20000) begin @(posedge clk); n++; end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_drain"}, rx_q.size(), 0);
    chk({tag, "_cur_x"}, int'(cur_x), mx);
    chk({tag, "_cur_y"}, int'(cur_y), my);
    chk({tag, "_n_writes"}, obs_w.size(), exp_w.size());
    foreach (exp_w[i]) if (i < obs_w.size()) chk({tag, "_write"}, int'(obs_w[i]), int'(exp_w[i]));
    chk({tag, "_n_echo"}, obs_e.size(), exp_e.size());
    foreach (exp_e[i]) if (i < obs_e.size()) chk({tag, "_echo"}, int'(obs_e[i]), int'(exp_e[i]));
    chk({tag, "_pops"}, rd_cnt, sent);
    chk({tag, "_pop_width"}, dbl_cnt, 0);
    clear_obs();
  endtask

  task automatic goto(input int tx, input int ty);
    while (my > ty) send3(8'h41);
    while (my < ty) send3(8'h42);
    while (mx < tx) send3(8'h43);
    while (mx > tx) send3(8'h44);
    verify("goto");
  endtask

  initial begin
    logic [7:0] b;
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_rd_uart", int'(rd_uart), 0);
    chk("rst_wr_uart", int'(wr_uart), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_wr_xyc", int'({wr_x, wr_y, wr_char}), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: "Hi"
    send(8'h48); send(8'h69);
    chk("t1_sent", sent, 2);
    verify("t1");

    // 2: wrap from bottom-right corner
    goto(79, 29);
    send(8'h5A);
    verify("t2");
    chk("t2_home_x", int'(cur_x), 0);
    chk("t2_home_y", int'(cur_y), 0);

    // 3: backspace mid-line and at column 0
    goto(5, 3);
    send(8'h08);
    verify("t3a");
    goto(0, 3);
    send(8'h08);
    verify("t3b");

    // 4: arrows, saturation, aborted escape
    goto(0, 0);
    send3(8'h44); send3(8'h41);
    verify("t4a");
    send3(8'h42);
    verify("t4b");
    send(8'h1B); send(8'h78); send(8'h51);
    verify("t4c");

    // Randomised byte stream against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 60; i++) begin
        case ($urandom_range(0, 10))
          0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
          5:             b = 8'h08;
          6:             b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
          7:             b = 8'h1B;
          8:             b = 8'h5B;
          9:             b = 8'(8'h41 + $urandom_range(0, 3));
          default:       b = 8'($urandom_range(0, 255));
        endcase
        send(b);
      end
      verify("rand");
    end
    send(8'h00);
    verify("rand_end");

`ifdef UART_ECHO_EN
    // 5: echo held off by tx_full
    tx_full = 1'b1;
    send(8'h61); send(8'h62);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_held_writes", obs_w.size(), 1);
    chk("t5_held_echo", obs_e.size(), 0);
    chk("t5_held_pops", rd_cnt, 1);
    tx_full = 1'b0;
    verify("t5");
`endif

    // 6: reset while a byte executes in CSI mode
    send(8'h1B); send(8'h5B);
    verify("t6a");
    send(8'h45);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_uart && n < 50);
    chk("t6_exec_seen", int'(rd_uart), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_cur_x", int'(cur_x), 0);
    chk("t6_rst_cur_y", int'(cur_y), 0);
    chk("t6_rst_rd_uart", int'(rd_uart), 0);
    chk("t6_rst_we", int'(we), 0);
    chk("t6_rst_wr_uart", int'(wr_uart), 0);
    repeat (2) @(posedge clk);
    rx_q.delete();
    mx = 0; my = 0; mesc = 0;
    clear_obs();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(8'h43);
    verify("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
